// File: rtl/mem_pkg.sv
// Shared encodings for the load/store data memory: access sizes, FSM states,
// default depth and the little-endian byte-lane mask helper.
package mem_pkg;

    localparam int DEFAULT_DEPTH = 256;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    typedef struct packed {
        logic        write;
        size_e       size;
        logic        isUnsigned;
        logic [1:0]  off;
        logic [31:0] data;
    } req_t;

    function automatic logic [3:0] laneMask(size_e size, logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << off;
            SIZE_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 single-port synchronous RAM with per-byte write enables and a
// registered read. No reset: contents survive a system reset.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          inClk,
    input  logic [3:0]    inWe,
    input  logic [AW-1:0] inAddr,
    input  logic [31:0]   inData,
    output logic [31:0]   outData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge inClk) begin
        for (int b = 0; b < 4; b++) begin
            if (inWe[b]) begin
                mem[inAddr][8*b +: 8] <= inData[8*b +: 8];
            end
        end
        outData <= mem[inAddr];
    end

endmodule

// File: rtl/data_memory.sv
// Byte/halfword/word load-store unit: IDLE -> ACCESS -> DONE handshake around
// data_mem_array, with alignment/range fault detection and load extension.
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        inClk,
    input  logic        inRstN,
    input  logic        inReq,
    input  logic        inWrite,
    input  logic [1:0]  inSize,
    input  logic        inUnsigned,
    input  logic [31:0] inAddr,
    input  logic [31:0] inData,
    output logic [31:0] outMem,
    output logic        outReady,
    output logic        outError
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] BYTES = 33'(4 * DEPTH);

    state_e        state;
    req_t          req;
    logic [AW-1:0] reqIdx;
    logic          faultQ;

    logic [3:0]    ramWe;
    logic [AW-1:0] ramAddr;
    logic [31:0]   ramWrData;
    logic [31:0]   ramRdData;
    logic          inFault;

    function automatic logic isFault(logic [1:0] size, logic [31:0] addr);
        logic bad;
        case (size_e'(size))
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = |addr[1:0];
            default:   bad = 1'b1;
        endcase
        return bad || ({1'b0, addr} >= BYTES);
    endfunction

    function automatic logic [31:0] storeLanes(size_e size, logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{data[7:0]}};
            SIZE_HALF: lanes = {2{data[15:0]}};
            default:   lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] extendLoad(logic [31:0] rd, size_e size,
                                               logic [1:0] off, logic isUnsigned);
        logic [31:0] sh;
        logic [31:0] val;
        sh = rd >> {off, 3'b000};
        case (size)
            SIZE_BYTE: val = isUnsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: val = isUnsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   val = rd;
        endcase
        return val;
    endfunction

    assign inFault = isFault(inSize, inAddr);

    // In IDLE the RAM reads at the incoming address so the word is already
    // registered by the time ACCESS extracts the lane.
    assign ramAddr   = (state == IDLE) ? inAddr[AW+1:2] : reqIdx;
    assign ramWrData = storeLanes(req.size, req.data);
    assign ramWe     = (state == ACCESS && req.write && inRstN)
                       ? laneMask(req.size, req.off) : 4'b0000;

    data_mem_array #(.DEPTH(DEPTH)) uArray (
        .inClk  (inClk),
        .inWe   (ramWe),
        .inAddr (ramAddr),
        .inData (ramWrData),
        .outData(ramRdData)
    );

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state    <= IDLE;
            req      <= '0;
            reqIdx   <= '0;
            faultQ   <= 1'b0;
            outMem   <= '0;
            outReady <= 1'b0;
            outError <= 1'b0;
        end else begin
            outReady <= 1'b0;
            outError <= 1'b0;
            case (state)
                IDLE: begin
                    if (inReq) begin
                        req    <= '{write: inWrite, size: size_e'(inSize),
                                    isUnsigned: inUnsigned, off: inAddr[1:0],
                                    data: inData};
                        reqIdx <= inAddr[AW+1:2];
                        faultQ <= inFault;
                        state  <= inFault ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req.write) begin
                        outMem <= extendLoad(ramRdData, req.size, req.off, req.isUnsigned);
                    end
                    state <= DONE;
                end
                DONE: begin
                    outReady <= 1'b1;
                    outError <= faultQ;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory against a byte-array model.
module tb_data_memory;

    localparam int DEPTH = 256;
    localparam int NBYTES = 4 * DEPTH;

    logic        inClk = 1'b0;
    logic        inRstN = 1'b0;
    logic        inReq = 1'b0;
    logic        inWrite = 1'b0;
    logic [1:0]  inSize = 2'b00;
    logic        inUnsigned = 1'b0;
    logic [31:0] inAddr = '0;
    logic [31:0] inData = '0;
    logic [31:0] outMem;
    logic        outReady;
    logic        outError;

    data_memory #(.DEPTH(DEPTH)) dut (
        .inClk     (inClk),
        .inRstN    (inRstN),
        .inReq     (inReq),
        .inWrite   (inWrite),
        .inSize    (inSize),
        .inUnsigned(inUnsigned),
        .inAddr    (inAddr),
        .inData    (inData),
        .outMem    (outMem),
        .outReady  (outReady),
        .outError  (outError)
    );

    always #5 inClk = ~inClk;

    typedef struct {
        logic [31:0] mem;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model [NBYTES];
    logic [31:0] lastLoad = '0;
    int          cyc = 0;
    int          nVec = 0;
    int          nChecks = 0;
    int          nFail = 0;
    logic        prevReady = 1'b0;

    always @(posedge inClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per completion pulse.
    always @(negedge inClk) begin
        if (!inRstN) begin
            prevReady = 1'b0;
        end else begin
            if (!outReady) check("error_without_ready", {31'b0, outError}, 32'd0);
            if (outReady) begin
                check("ready_back_to_back", {31'b0, prevReady}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("outMem", outMem, e.mem);
                    check("outError", {31'b0, outError}, {31'b0, e.err});
                    check("latency", 32'(cyc - e.issue), 32'(e.lat));
                end
            end
            prevReady = outReady;
        end
    end

    function automatic bit modelFault(logic [1:0] sz, logic [31:0] a);
        int n;
        if (sz == 2'd3) return 1'b1;
        n = 1 << sz;
        return ((a % n) != 0) || (longint'(a) >= NBYTES);
    endfunction

    function automatic logic [31:0] modelLoad(logic [1:0] sz, logic u, logic [31:0] a);
        int     n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(model[a + i]) << (8 * i));
        if (!u && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Called at a falling edge while the DUT is idle; returns at the falling
    // edge where the completion pulse is visible.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input bit keep);
        exp_t e;
        int   n;
        inWrite = w; inSize = sz; inUnsigned = u; inAddr = a; inData = d;
        inReq = 1'b1;
        nVec++;
        e.issue = cyc;
        if (modelFault(sz, a)) begin
            e.err = 1'b1; e.mem = lastLoad; e.lat = 2;
        end else if (w) begin
            for (int i = 0; i < (1 << sz); i++) model[a + i] = d[8*i +: 8];
            e.err = 1'b0; e.mem = lastLoad; e.lat = 3;
        end else begin
            lastLoad = modelLoad(sz, u, a);
            e.err = 1'b0; e.mem = lastLoad; e.lat = 3;
        end
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge inClk);
            n++;
        end while (!outReady && n < 20);
        if (!outReady) begin
            nChecks++;
            nFail++;
            $display("FAIL timeout: no outReady after %0d cycles, expected within 3", n);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        if (!keep) inReq = 1'b0;
    endtask

    task automatic randomReq(input bit keep);
        logic [1:0]  sz;
        logic [31:0] a;
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, NBYTES - 1));
        if (sz != 2'd3 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 1);
        if ($urandom_range(0, 19) == 0) a = (($urandom_range(0, 1) == 0) ? 32'(NBYTES) : $urandom()) + 32'($urandom_range(0, 64));
        issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), keep);
    endtask

    initial begin
        #1;
        check("reset_outMem", outMem, 32'd0);
        check("reset_outReady", {31'b0, outReady}, 32'd0);
        check("reset_outError", {31'b0, outError}, 32'd0);
        repeat (3) @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom(), 1'($urandom_range(0, 1)));
        inReq = 1'b0;
        @(negedge inClk);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'(NBYTES), 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h11111111, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h22222222, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'(NBYTES), 32'h33333333, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);

        for (int i = 0; i < 12; i++) randomReq(1'b1);
        inReq = 1'b0;

        for (int i = 0; i < 300; i++) begin
            randomReq(1'($urandom_range(0, 1)));
            if (!inReq) repeat ($urandom_range(0, 2)) @(negedge inClk);
        end
        inReq = 1'b0;
        @(negedge inClk);

        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        inWrite = 1'b1; inSize = 2'd2; inUnsigned = 1'b0; inAddr = 32'h20; inData = 32'h12345678;
        inReq = 1'b1;
        @(posedge inClk);
        #2;
        inRstN = 1'b0;
        inReq = 1'b0;
        #1;
        check("midreset_outMem", outMem, 32'd0);
        check("midreset_outReady", {31'b0, outReady}, 32'd0);
        check("midreset_outError", {31'b0, outError}, 32'd0);
        lastLoad = '0;
        repeat (2) @(negedge inClk);
        inRstN = 1'b1;
        @(negedge inClk);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0);

        repeat (5) @(negedge inClk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: DEPTH, default 256, number of 32-bit words; byte address space 4*DEPTH.
REQ-002 inClk  input  1  single clock; all state updates on rising edge.
REQ-003 inRstN  input  1  reset, asynchronous, active-low.
REQ-004 inReq  input  1  access request; held by requester until outReady.
REQ-005 inWrite  input  1  1 = store, 0 = load.
REQ-006 inSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 inUnsigned  input  1  1 = zero-extend load, 0 = sign-extend load.
REQ-008 inAddr  input  32  byte address from the ALU result.
REQ-009 inData  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 outMem  output  32  load result; feeds the memory input of the writeback select stage.
REQ-011 outReady  output  1  one-cycle completion pulse.
REQ-012 outError  output  1  fault flag, valid only with outReady.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-014 IDLE with inReq=1 SHALL latch inWrite, inSize, inUnsigned, inAddr and inData, then go to ACCESS; otherwise it stays in IDLE.
REQ-015 Inputs SHALL be sampled only in IDLE; changes during ACCESS and DONE are ignored.
REQ-016 A fault SHALL be any of: inSize=11; halfword with addr[0]=1; word with addr[1:0]!=00; addr >= 4*DEPTH.
REQ-017 A faulting request SHALL go IDLE->DONE directly, perform no write, leave outMem unchanged, and assert outError=1 with outReady.
REQ-018 In ACCESS, a store SHALL write only the addressed little-endian byte lanes on the closing edge: byte lane addr[1:0], halfword lanes {addr[1],0} and {addr[1],1}, word all four lanes.
REQ-019 In ACCESS, a load SHALL read the addressed word, extract the addressed lane, and sign- or zero-extend it to 32 bits into outMem on the closing edge.
REQ-020 ACCESS SHALL always go to DONE after one cycle.
REQ-021 DONE SHALL assert outReady=1 for exactly one cycle and return to IDLE.
REQ-022 Latency: a request accepted at edge N SHALL see outReady high in the cycle after edge N+2 for non-faulting requests and after edge N+1 for faults.
REQ-023 Maximum throughput SHALL be one access per 3 cycles.
REQ-024 inReq still high in IDLE after DONE SHALL be treated as a new request.
REQ-025 outMem SHALL hold the last successful load value; stores and faults SHALL not change it.
REQ-026 outError SHALL be 0 whenever outReady=0.

Reset
REQ-027 inRstN=0 SHALL immediately force state IDLE, outMem=0, outReady=0, outError=0, and clear the latched request registers.
REQ-028 The memory array SHALL not be reset; its contents persist across reset.
REQ-029 Reset asserted during ACCESS SHALL suppress the pending write; no partial store is permitted.
REQ-030 After deassertion, the first request SHALL be accepted at the first rising edge with inReq=1.

Structure
REQ-031 Shared package mem_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), FSM state encodings and the default DEPTH.
REQ-032 The storage SHALL be a sub-module data_mem_array: DEPTH x 32 synchronous RAM with a 4-bit byte-write enable and a registered read; lane extraction and fault checks stay in data_memory.

Verification
REQ-033 Word store 0xDEADBEEF at 0x10, then word load 0x10 -> outMem=0xDEADBEEF, outError=0, outReady 2 cycles after acceptance.
REQ-034 After REQ-033: signed byte load 0x13 -> 0xFFFFFFDE; unsigned byte load 0x13 -> 0x000000DE; signed halfword load 0x10 -> 0xFFFFBEEF.
REQ-035 Byte store 0x55 at 0x11 over 0xDEADBEEF, then word load 0x10 -> 0xDEAD55EF; the other lanes are unchanged.
REQ-036 Word load 0x12 (misaligned), inSize=11, and word load 4*DEPTH -> outReady and outError one cycle after acceptance; memory and outMem are unchanged.
REQ-037 Word store 0x12345678 at 0x20 with inRstN pulsed low during ACCESS -> outputs 0 at once; a later load 0x20 returns the prior contents.
REQ-038 inReq held high continuously -> accepts every 3 cycles; outReady is never high for 2 consecutive cycles.
